// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle MIPS-subset control FSM.
//   state_e   4-bit FSM state encoding (also exported on state_dbg)
//   OP_*      IR[31:26] opcodes understood by the controller
//   ALUOP_*, SRCB_*, PCSRC_*  datapath mux/ALU encodings
//   ctrl_t    one control word carrying every datapath strobe
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_INC    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// mc_ctrl_decode: combinational state -> control word (Moore outputs, before mem_ready/reset gating).
//   state_i  current FSM state
//   ctrl_o   raw control word for that state
// Optional: MC_CTRL_ADDI_EN adds the ADDI_EXEC/ADDI_WB rows.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH;
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mem_read  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_IMM;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_BRANCH;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.reg_write = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS-subset datapath.
//   clk, reset (sync, active-high), opCode (IR[31:26]), mem_ready (memory access completes)
//   -> every datapath strobe, sticky illegal_op, retired-instruction counter, state_dbg.
// Optional: MC_CTRL_ADDI_EN enables ADDI (opcode 08); otherwise 08 halts as illegal.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opCode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_dbg
);

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                illegal_q;
    logic                retire;
    ctrl_t               dec, ctrl;

    mc_ctrl_decode u_decode (
        .state_i(state_q),
        .ctrl_o (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opCode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            default:     state_d = S_HALT;
        endcase
    end

    // Only final states can return to FETCH, so any non-FETCH -> FETCH move retires one instruction.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + RETIRE_W'(1);
            if (state_d == S_HALT) illegal_q <= 1'b1;
        end
    end

    // PC/IR load in FETCH only completes when memory delivers the instruction word.
    always_comb begin
        ctrl = dec;
        if (state_q == S_FETCH) begin
            ctrl.pc_write = dec.pc_write & mem_ready;
            ctrl.ir_write = dec.ir_write & mem_ready;
        end
        if (reset) ctrl = '0;
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign illegal_op  = ~reset & illegal_q;
    assign retired     = reset ? '0 : retired_q;
    assign state_dbg   = reset ? 4'h0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction-level check of the multicycle control FSM.
module tb_multicycle_control;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset, mem_ready;
    logic [5:0]    opCode;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic          IRWrite, RegWrite, RegDst, ALUSrcA, illegal_op;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic [RW-1:0] retired;
    logic [3:0]    state_dbg;
    logic [15:0]   obs;

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    int n_checks = 0;
    int n_fail   = 0;
    int m_state, m_retired;
    bit m_illegal;
    int c_irw, c_rw, c_mw, c_pcwc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control word required in state s, built field by field from the controller's documented rows.
    function automatic logic [15:0] exp_ctrl(input int s, input bit mr);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, rw = 0, rd = 0, sa = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        if (s == 0) begin mrd = 1; sb = 2'b01; pcw = mr; irw = mr; end
        if (s == 1) sb = 2'b11;
        if (s >= 2 && s <= 5) begin sa = 1; sb = 2'b10; end
        if (s >= 3 && s <= 5) iord = 1;
        if (s == 3) mrd = 1;
        if (s == 4) m2r = 1;
        if (s == 5) mwr = 1;
        if (s == 4 || s == 7 || s == 11) rw = 1;
        if (s == 6 || s == 7) begin sa = 1; op = 2'b10; end
        if (s == 7) rd = 1;
        if (s == 8) begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; end
        if (s == 9) begin pcw = 1; ps = 2'b10; end
        if (s == 10 || s == 11) begin sa = 1; sb = 2'b10; end
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, sa, sb, op, ps};
    endfunction

    task automatic cyc(input bit mr, input logic [5:0] op);
        mem_ready = mr;
        opCode    = op;
        @(negedge clk);
        check("state", state_dbg, m_state);
        check("ctrl", obs, exp_ctrl(m_state, mr));
        check("retired", retired, m_retired);
        check("illegal", illegal_op, m_illegal);
        c_irw  += IRWrite;
        c_rw   += RegWrite;
        c_mw   += MemWrite;
        c_pcwc += PCWriteCond;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'($urandom);
        opCode    = 6'($urandom);
        @(negedge clk);
        check("rst_ctrl", obs, 16'h0);
        check("rst_state", state_dbg, 0);
        check("rst_retired", retired, 0);
        check("rst_illegal", illegal_op, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_state   = 0;
        m_retired = 0;
        m_illegal = 0;
    endtask

    // Run one instruction from FETCH: fw wait cycles on the fetch, mw on the data access.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int path[$];
        bit writes;
        case (op)
            6'h23:   path = '{0, 1, 2, 3, 4};
            6'h2B:   path = '{0, 1, 2, 5};
            6'h00:   path = '{0, 1, 6, 7};
            6'h04:   path = '{0, 1, 8};
            6'h02:   path = '{0, 1, 9};
`ifdef MC_CTRL_ADDI_EN
            6'h08:   path = '{0, 1, 10, 11};
`endif
            default: path = '{0, 1, 15};
        endcase
        c_irw = 0; c_rw = 0; c_mw = 0; c_pcwc = 0;
        foreach (path[i]) begin
            int s, waits;
            s     = path[i];
            waits = (s == 0) ? fw : (s == 3 || s == 5) ? mw : 0;
            m_state = s;
            if (s == 15) m_illegal = 1;
            for (int w = 0; w < waits; w++) cyc(1'b0, (s == 0) ? 6'($urandom) : op);
            cyc((s == 0 || s == 3 || s == 5) ? 1'b1 : 1'($urandom), (s == 0) ? 6'($urandom) : op);
        end
        if (m_state != 15) begin
            writes = (op == 6'h23) || (op == 6'h00);
`ifdef MC_CTRL_ADDI_EN
            writes |= (op == 6'h08);
`endif
            m_retired = (m_retired + 1) % (1 << RW);
            m_state   = 0;
            check("irwrite_cnt", c_irw, 1);
            check("regwrite_cnt", c_rw, writes);
            check("memwrite_cnt", c_mw, (op == 6'h2B) ? mw + 1 : 0);
            check("pcwcond_cnt", c_pcwc, op == 6'h04);
        end
    endtask

    task automatic halt_tail();
        for (int i = 0; i < 10; i++) cyc(1'($urandom), 6'($urandom));
        do_reset();
        cyc(1'b0, 6'($urandom));
    endtask

    initial begin
        logic [5:0] ops [5];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02};
        reset = 1'b1; mem_ready = 1'b0; opCode = 6'h0;
        do_reset();
        run_instr(6'h23, 0, 0);
        run_instr(6'h2B, 0, 3);
        run_instr(6'h00, 2, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 1, 0);
        run_instr(6'h08, 0, 0);
        if (m_state == 15) halt_tail();
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 3));
        // reset while MemWrite is waiting on memory: instruction is abandoned, counter cleared
        m_state = 0; cyc(1'b1, 6'h11);
        m_state = 1; cyc(1'b0, 6'h2B);
        m_state = 2; cyc(1'b0, 6'h2B);
        m_state = 5; cyc(1'b0, 6'h2B);
        cyc(1'b0, 6'h2B);
        do_reset();
        cyc(1'b0, 6'h2B);
        run_instr(6'h3F, 0, 0);
        halt_tail();
        run_instr(6'h23, 1, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
